uart_bus_master: RTL and testbench

UART-driven bus initiator: consumes a byte stream from a UART receive FIFO, assembles read/write commands and issues single-cycle accesses on the processor-style system bus (address / write data / rd_en / wr_en, combinational read data). Responses are returned as bytes into a UART transmit FIFO. The block gives a host PC a debug and loader path into memory-mapped space without the processor.

---
 rtl/uart_bus_master.sv | 157 +++++++++++++++
 tb/tb_uart_bus_master.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: assembles R/W commands from an RX byte FIFO,
// performs single-cycle bus accesses and returns response bytes to a TX FIFO.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  OP_WRITE       = 8'h57,
    parameter logic [7:0]  OP_READ        = 8'h52
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_rd,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_full,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    output logic        bus_wr_en,
    output logic        bus_rd_en,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        cmd_err,
    output logic        timeout_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_SEND  = 3'd5;

    localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 1;

    logic [2:0]  r_state;
    logic        r_is_wr;
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;
    logic [2:0]  r_tx_cnt;
    logic [31:0] r_tmo;
    logic        r_cmd_err;
    logic        r_tmo_err;

    logic        w_rx_state;
    logic [31:0] w_shifted;
    logic        w_tmo_hit;

    assign w_rx_state = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
    // Gated by reset so the pop strobe is inactive while the block is held in reset.
    assign rx_rd      = reset && !rx_empty && w_rx_state;
    assign tx_wr      = (r_state == ST_SEND) && !tx_full;
    assign tx_data    = r_resp[31:24];
    assign w_shifted  = {r_shift, rx_data};
    assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_LAST);

    assign bus_address = r_addr;
    assign bus_wdata   = r_wdata;
    assign bus_wr_en   = (r_state == ST_WRITE);
    assign bus_rd_en   = (r_state == ST_READ);
    assign busy        = (r_state != ST_IDLE);
    assign cmd_err     = r_cmd_err;
    assign timeout_err = r_tmo_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_is_wr   <= 1'b0;
            r_cnt     <= 2'd0;
            r_shift   <= 24'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_resp    <= 32'd0;
            r_tx_cnt  <= 3'd0;
            r_tmo     <= 32'd0;
            r_cmd_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            r_tmo_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_rd) begin
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            r_is_wr <= (rx_data == OP_WRITE);
                            r_cnt   <= 2'd0;
                            r_tmo   <= 32'd0;
                            r_state <= ST_ADDR;
                        end else begin
                            r_cmd_err <= 1'b1;
                            r_resp    <= {8'h3F, 24'd0};
                            r_tx_cnt  <= 3'd1;
                            r_state   <= ST_SEND;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_rd) begin
                        r_shift <= w_shifted[23:0];
                        r_cnt   <= r_cnt + 2'd1;
                        r_tmo   <= 32'd0;
                        // bus_address only changes once the full address is known
                        if (r_cnt == 2'd3) begin
                            r_addr  <= w_shifted;
                            r_state <= r_is_wr ? ST_DATA : ST_READ;
                        end
                    end else if (w_tmo_hit) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_rd) begin
                        r_shift <= w_shifted[23:0];
                        r_cnt   <= r_cnt + 2'd1;
                        r_tmo   <= 32'd0;
                        if (r_cnt == 2'd3) begin
                            r_wdata <= w_shifted;
                            r_state <= ST_WRITE;
                        end
                    end else if (w_tmo_hit) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                ST_WRITE: begin
                    r_resp   <= {8'h4B, 24'd0};
                    r_tx_cnt <= 3'd1;
                    r_state  <= ST_SEND;
                end
                ST_READ: begin
                    r_resp   <= bus_rdata;
                    r_tx_cnt <= 3'd4;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    // Shift the next response byte into [31:24] after each accepted push
                    if (tx_wr) begin
                        r_resp   <= {r_resp[23:0], 8'd0};
                        r_tx_cnt <= r_tx_cnt - 3'd1;
                        if (r_tx_cnt == 3'd1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: byte-level command model with expected bus and TX
// queues, a per-cycle compare process, and directed latency/value checks.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_full;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        cmd_err;
    logic        timeout_err;

    int n_tot = 0;
    int n_bad = 0;

    logic [7:0]  rxbuf [0:255];
    int          rx_head = 0;
    int          rx_tail = 0;

    logic [31:0] mem     [0:15];
    logic [31:0] mdl_mem [0:15];

    bit          exp_kind [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_wd   [$];
    logic [7:0]  exp_tx   [$];
    logic [7:0]  tx_log   [$];
    int          exp_cmderr = 0;
    int          exp_tmo = 0;
    int          n_cmderr_seen = 0;
    bit          c_prev_wr = 1'b0;
    bit          c_prev_rd = 1'b0;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_rdata(bus_rdata),
        .busy(busy), .cmd_err(cmd_err), .timeout_err(timeout_err)
    );

    assign rx_empty  = (rx_head == rx_tail);
    assign rx_data   = rxbuf[rx_head[7:0]];
    assign bus_rdata = bus_rd_en ? mem[bus_address[5:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) if (rx_rd) rx_head <= rx_head + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxbuf[rx_tail[7:0]] = b;
        rx_tail++;
    endtask

    task automatic push_word(input logic [31:0] w);
        push_byte(w[31:24]);
        push_byte(w[23:16]);
        push_byte(w[15:8]);
        push_byte(w[7:0]);
    endtask

    // Model: each command maps to its bus access and its response bytes.
    task automatic cmd_write(input logic [31:0] a, input logic [31:0] d);
        push_byte(8'h57);
        push_word(a);
        push_word(d);
        exp_kind.push_back(1'b1);
        exp_addr.push_back(a);
        exp_wd.push_back(d);
        mdl_mem[a[5:2]] = d;
        exp_tx.push_back(8'h4B);
    endtask

    task automatic cmd_read(input logic [31:0] a);
        logic [31:0] d;
        push_byte(8'h52);
        push_word(a);
        exp_kind.push_back(1'b0);
        exp_addr.push_back(a);
        exp_wd.push_back(32'h0);
        d = mdl_mem[a[5:2]];
        exp_tx.push_back(d[31:24]);
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
    endtask

    task automatic cmd_bad(input logic [7:0] op);
        push_byte(op);
        exp_cmderr++;
        exp_tx.push_back(8'h3F);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (k < 300 && !(rx_head == rx_tail && !busy && exp_kind.size() == 0 &&
               exp_tx.size() == 0 && exp_cmderr == 0 && exp_tmo == 0)) begin
            tick();
            k++;
        end
        n_tot++;
        if (k >= 300) begin
            n_bad++;
            $display("FAIL %s: not finished after %0d cycles, tx left %0d", nm, k, exp_tx.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_rx_rd"}, rx_rd, 1'b0);
        chk1({tag, "_tx_wr"}, tx_wr, 1'b0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_bus_address"}, bus_address, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        chk1({tag, "_bus_wr_en"}, bus_wr_en, 1'b0);
        chk1({tag, "_bus_rd_en"}, bus_rd_en, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_cmd_err"}, cmd_err, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    // Compare process: bus slave plus every-cycle check against the model queues.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[1] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            if (!reset) begin
                c_prev_wr = 1'b0;
                c_prev_rd = 1'b0;
                continue;
            end
            if (bus_wr_en || bus_rd_en) begin
                chk1("strobe_exclusive", bus_wr_en & bus_rd_en, 1'b0);
                chk1("no_pop_during_access", rx_rd, 1'b0);
                if (exp_kind.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL bus_extra: strobe wr=%b rd=%b at %h, none expected", bus_wr_en, bus_rd_en, bus_address);
                end else begin
                    bit          k;
                    logic [31:0] a;
                    logic [31:0] d;
                    k = exp_kind.pop_front();
                    a = exp_addr.pop_front();
                    d = exp_wd.pop_front();
                    chk1("bus_kind_is_write", bus_wr_en, k);
                    chk("bus_address", bus_address, a);
                    if (k) chk("bus_wdata", bus_wdata, d);
                end
                if (bus_wr_en) mem[bus_address[5:2]] = bus_wdata;
            end
            if (bus_wr_en) chk1("wr_strobe_one_cycle", c_prev_wr, 1'b0);
            if (bus_rd_en) chk1("rd_strobe_one_cycle", c_prev_rd, 1'b0);
            if (tx_wr) begin
                tx_log.push_back(tx_data);
                chk1("no_pop_during_send", rx_rd, 1'b0);
                if (exp_tx.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL tx_extra: pushed %h, none expected", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
                end
            end
            if (cmd_err) begin
                n_cmderr_seen++;
                n_tot++;
                if (exp_cmderr > 0) exp_cmderr--;
                else begin
                    n_bad++;
                    $display("FAIL cmd_err_extra: got 1 expected 0");
                end
            end
            if (timeout_err) begin
                n_tot++;
                if (exp_tmo > 0) exp_tmo--;
                else begin
                    n_bad++;
                    $display("FAIL timeout_err_extra: got 1 expected 0");
                end
            end
            c_prev_wr = bus_wr_en;
            c_prev_rd = bus_rd_en;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'hC0DE_0000 + i;
        mdl_mem[1] = 32'h1234_5678;
        reset   = 1'b0;
        tx_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // Write 0x3000 <= DEADBEEF, with latency pinned
        base = tx_log.size();
        cmd_write(32'h0000_3000, 32'hDEAD_BEEF);
        cnt = 0;
        while (cnt < 50 && !bus_wr_en) begin tick(); cnt++; end
        chk("wr_latency", cnt, 9);
        tick();
        chk1("wr_k_latency", tx_wr, 1'b1);
        wait_done("write");
        chk("wr_resp", {24'd0, tx_log[base]}, 32'h4B);
        chk("wr_mem", mem[0], 32'hDEAD_BEEF);
        chk("wr_addr_hold", bus_address, 32'h0000_3000);
        chk("wr_wdata_hold", bus_wdata, 32'hDEAD_BEEF);

        // Read 0x1004, four response bytes in consecutive cycles
        base = tx_log.size();
        cmd_read(32'h0000_1004);
        cnt = 0;
        while (cnt < 50 && !bus_rd_en) begin tick(); cnt++; end
        chk("rd_latency", cnt, 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("rd_tx_consecutive", tx_wr, 1'b1);
        end
        wait_done("read");
        chk("rd_b0", {24'd0, tx_log[base]},     32'h12);
        chk("rd_b1", {24'd0, tx_log[base + 1]}, 32'h34);
        chk("rd_b2", {24'd0, tx_log[base + 2]}, 32'h56);
        chk("rd_b3", {24'd0, tx_log[base + 3]}, 32'h78);

        // TX back-pressure after the first response byte
        base = tx_log.size();
        cmd_read(32'h0000_1004);
        cnt = 0;
        while (cnt < 50 && !tx_wr) begin tick(); cnt++; end
        chk("bp_first_push", cnt, 6);
        tick();
        tx_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_tx_data_stable", {24'd0, tx_data}, 32'h34);
            chk1("bp_no_tx_wr", tx_wr, 1'b0);
            tick();
        end
        tx_full = 1'b0;
        wait_done("backpressure");
        chk("bp_byte_count", tx_log.size() - base, 4);
        chk("bp_b1", {24'd0, tx_log[base + 1]}, 32'h34);

        // Unknown opcode, then back-to-back write and read
        base = tx_log.size();
        cmd_bad(8'hA5);
        cmd_write(32'h0000_1008, 32'h0BAD_F00D);
        cmd_read(32'h0000_1008);
        wait_done("badop_then_cmds");
        chk("bad_resp", {24'd0, tx_log[base]}, 32'h3F);
        chk("bad_cmd_err_count", n_cmderr_seen, 1);
        chk("b2b_k", {24'd0, tx_log[base + 1]}, 32'h4B);
        chk("b2b_b0", {24'd0, tx_log[base + 2]}, 32'h0B);
        chk("b2b_b3", {24'd0, tx_log[base + 5]}, 32'h0D);

        // Inter-byte timeout
        push_byte(8'h57);
        push_byte(8'h00);
        exp_tmo = 1;
        cnt = 0;
        while (cnt < 100 && !timeout_err) begin tick(); cnt++; end
        chk("tmo_latency", cnt, 18);
        chk1("tmo_busy_low", busy, 1'b0);
        tick();
        chk1("tmo_pulse_one_cycle", timeout_err, 1'b0);
        base = tx_log.size();
        cmd_read(32'h0000_3000);
        wait_done("read_after_timeout");
        chk("tmo_rd_b0", {24'd0, tx_log[base]},     32'hDE);
        chk("tmo_rd_b3", {24'd0, tx_log[base + 3]}, 32'hEF);

        // Asynchronous reset in the middle of a command
        push_byte(8'h57);
        push_byte(8'h00);
        push_byte(8'h00);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        tick();
        reset = 1'b1;
        tick();
        base = tx_log.size();
        cmd_read(32'h0000_1004);
        wait_done("read_after_reset");
        chk("rst_rd_b0", {24'd0, tx_log[base]},     32'h12);
        chk("rst_rd_b3", {24'd0, tx_log[base + 3]}, 32'h78);

        repeat (3) tick();
        chk("left_bus", exp_kind.size(), 0);
        chk("left_tx", exp_tx.size(), 0);
        chk("left_rx", rx_tail - rx_head, 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
